// File: rtl/save_read_engine.sv
// Save read sequencer: walks a line range of the result buffer and streams
// the returned lines out through a credit-protected skid FIFO.
module save_read_engine #(
  parameter int BUFFER_ADDR_WIDTH = 11,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int LEN_WIDTH         = 12,
  parameter int FIFO_DEPTH        = 8,
  parameter int READ_LATENCY      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_length,
  output logic                         save_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] save_read_addr,
  input  logic                         save_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0] save_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         done
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [OCC_W-1:0]     OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0]     OCC_MAX = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);

  logic [1:0]                   state_q, state_d;
  logic [BUFFER_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [LEN_WIDTH-1:0]         issued_q, issued_d;
  logic [LEN_WIDTH-1:0]         popped_q, popped_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic                         rd_v_q, rd_v_d;
  logic [BUFFER_ADDR_WIDTH-1:0] rd_a_q, rd_a_d;
  logic                         done_q, done_d;

  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]             cnt_q;
  logic [BUFFER_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic cmd_fire;
  logic fifo_empty;
  logic push;
  logic pop;
  logic issue;
  logic last_beat;

  assign cmd_ready  = (state_q == S_IDLE);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign fifo_empty = (cnt_q == '0);
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign pop        = out_valid & out_ready;
  assign last_beat  = ((popped_q + LEN_ONE) == len_q);
  assign out_last   = out_valid & last_beat;

  // Returns landing while idle belong to an aborted command.
  assign push = save_read_data_valid & (state_q != S_IDLE);

  assign save_read_addr_valid = rd_v_q;
  assign save_read_addr       = rd_a_q;
  assign done                 = done_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = pop ? (popped_q + LEN_ONE) : popped_q;
    rd_a_d   = '0;
    done_d   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          base_d   = cmd_base_addr;
          len_d    = cmd_length;
          popped_d = '0;
          if (cmd_length == '0) begin
            issued_d = '0;
            done_d   = 1'b1;
          end else begin
            // First read goes out with the acceptance edge.
            issue    = 1'b1;
            rd_a_d   = cmd_base_addr;
            issued_d = LEN_ONE;
            state_d  = (cmd_length == LEN_ONE) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if ((issued_q < len_q) && (occ_q < OCC_MAX)) begin
          issue    = 1'b1;
          rd_a_d   = base_q + BUFFER_ADDR_WIDTH'(issued_q);
          issued_d = issued_q + LEN_ONE;
          if (issued_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && last_beat) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_v_d = issue;
  end

  // Credit counts reads in flight plus lines parked in the FIFO.
  always_comb begin
    occ_d = occ_q;
    if (issue && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!issue && pop) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      occ_q    <= '0;
      rd_v_q   <= 1'b0;
      rd_a_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      occ_q    <= occ_d;
      rd_v_q   <= rd_v_d;
      rd_a_q   <= rd_a_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + OCC_ONE;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= save_read_data;
    end
  end

endmodule

// File: tb/tb_save_read_engine.sv
// Directed bench for save_read_engine with a fixed-latency buffer model
// and a negedge stream monitor.
module tb_save_read_engine;

  localparam int AW = 11;
  localparam int DW = 512;
  localparam int LW = 12;
  localparam int FD = 8;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [LW-1:0] cmd_length = '0;
  logic          save_read_addr_valid;
  logic [AW-1:0] save_read_addr;
  logic          save_read_data_valid;
  logic [DW-1:0] save_read_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  always #5 clk = ~clk;

  save_read_engine #(
    .BUFFER_ADDR_WIDTH(AW),
    .BUFFER_DATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .FIFO_DEPTH(FD),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_length(cmd_length),
    .save_read_addr_valid(save_read_addr_valid),
    .save_read_addr(save_read_addr),
    .save_read_data_valid(save_read_data_valid),
    .save_read_data(save_read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .done(done)
  );

  function automatic logic [DW-1:0] bufline(input logic [AW-1:0] a);
    return {16{16'hC0DE, 5'b0, a}};
  endfunction

  // Buffer model: fixed latency, not reset, so aborted reads still return.
  logic [RL-1:0] pv = '0;
  logic [AW-1:0] pa [RL];
  always @(posedge clk) begin
    pv <= {pv[RL-2:0], save_read_addr_valid};
    pa[0] <= save_read_addr;
    for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
  end
  assign save_read_data_valid = pv[RL-1];
  assign save_read_data = bufline(pa[RL-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_rd, n_pop, done_cnt, done_cyc, first_cyc, max_occ, stall_bad, acc;
  logic held;
  logic [DW-1:0] prev;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  bit last_q[$];

  task automatic clear_stats();
    n_rd = 0; n_pop = 0; done_cnt = 0; done_cyc = -1;
    first_cyc = -1; max_occ = 0; stall_bad = 0; held = 1'b0;
    addr_q.delete(); data_q.delete(); last_q.delete();
  endtask

  always @(negedge clk) begin
    if (save_read_addr_valid) begin
      n_rd++;
      addr_q.push_back(save_read_addr);
    end
    if (n_rd - n_pop > max_occ) max_occ = n_rd - n_pop;
    if (out_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      if (held && out_data !== prev) stall_bad++;
      if (out_ready) begin
        n_pop++;
        data_q.push_back(out_data);
        last_q.push_back(out_last);
        held = 1'b0;
      end else begin
        held = 1'b1;
        prev = out_data;
      end
    end else begin
      held = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base_addr = b;
    cmd_length = l;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit tog);
    int start;
    bit ok;
    start = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (tog) out_ready = ~out_ready;
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    chk({tag, " done_seen"}, ok, 1'b1);
  endtask

  task automatic verify(input string tag, input logic [AW-1:0] b,
                        input int len);
    logic [AW-1:0] ea;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " reads"}, n_rd, len);
    chk({tag, " beats"}, n_pop, len);
    chk({tag, " done_cnt"}, done_cnt, 1);
    for (int i = 0; i < len; i++) begin
      ea = b + AW'(i);
      chk({tag, " addr"}, (i < addr_q.size()) ? addr_q[i] : 'x, ea);
      chk({tag, " data"}, (i < data_q.size()) ? data_q[i] : 'x, bufline(ea));
      chk({tag, " last"}, (i < last_q.size()) ? last_q[i] : 1'bx,
          (i == len - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst rd_valid", save_read_addr_valid, 1'b0);
    chk("rst rd_addr", save_read_addr, '0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_last", out_last, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    clear_stats();
    send_cmd(11'h010, 12'd4);
    wait_done("basic", 50, 1'b0);
    verify("basic", 11'h010, 4);
    chk("basic first_lat", first_cyc - acc, 5);
    chk("basic done_lat", done_cyc - acc, 9);

    clear_stats();
    send_cmd(11'h7FE, 12'd4);
    wait_done("wrap", 50, 1'b0);
    verify("wrap", 11'h7FE, 4);

    clear_stats();
    out_ready = 1'b0;
    send_cmd(11'h200, 12'd20);
    repeat (30) @(posedge clk);
    #1;
    chk("stall reads", n_rd, 8);
    chk("stall beats", n_pop, 0);
    out_ready = 1'b1;
    wait_done("stall", 100, 1'b0);
    verify("stall", 11'h200, 20);
    chk("stall max_occ", max_occ, 8);

    clear_stats();
    send_cmd(11'h300, 12'd16);
    wait_done("toggle", 200, 1'b1);
    verify("toggle", 11'h300, 16);
    chk("toggle stable", stall_bad, 0);
    chk("toggle occ_le8", (max_occ <= 8), 1'b1);

    clear_stats();
    send_cmd(11'h055, 12'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("zero reads", n_rd, 0);
    chk("zero beats", n_pop, 0);
    chk("zero done_cnt", done_cnt, 1);
    chk("zero done_lat", done_cyc - acc, 0);

    clear_stats();
    send_cmd(11'h020, 12'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("abort rd_valid", save_read_addr_valid, 1'b1);
    chk("abort rd_addr", save_read_addr, 11'h022);
    rst_n = 1'b0;
    #1;
    chk("abort cmd_ready", cmd_ready, 1'b1);
    chk("abort rd_valid_rst", save_read_addr_valid, 1'b0);
    chk("abort rd_addr_rst", save_read_addr, '0);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    repeat (8) @(posedge clk);
    #1;
    chk("abort late_beats", n_pop, 0);
    chk("abort late_valid", (first_cyc < 0), 1'b1);

    clear_stats();
    send_cmd(11'h100, 12'd2);
    wait_done("after", 50, 1'b0);
    verify("after", 11'h100, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
